// File: rtl/mem_arbiter_pkg.sv
// Types and constants for the split-port to single-port memory arbiter.
package mem_arbiter_types;

  localparam int unsigned BE_W = 4;

  // Fetches always access the full word.
  localparam logic [BE_W-1:0] BE_FULL = {BE_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INST = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_INST = 1'b0,
    GRANT_DATA = 1'b1
  } grant_t;

endpackage : mem_arbiter_types

// File: rtl/rv32i_types.sv
// Shared RV32I datapath types used by the memory-side blocks.
package rv32i_types;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] rv32i_word;

endpackage : rv32i_types

// File: rtl/mem_arbiter.sv
// mem_arbiter: serves the CPU instruction and data memory ports from one
// shared physical memory port.
//   clk, rst (async, active-low)
//   inst_mem_*  : instruction port (read-only; write/wdata/byte_enable unused)
//   data_mem_*  : data port (read/write with byte enables)
//   pmem_*      : shared physical memory port; request side registered,
//                 CPU resp pulses are combinational from pmem_resp
//   FAIR        : 1 = alternate grants on contention, 0 = data port wins
module mem_arbiter
  import mem_arbiter_types::*;
  import rv32i_types::*;
#(
  parameter bit FAIR = 1'b1
) (
  input  logic            clk,
  input  logic            rst,

  input  rv32i_word       inst_mem_address,
  input  logic            inst_mem_read,
  input  logic            inst_mem_write,
  input  rv32i_word       inst_mem_wdata,
  input  logic [BE_W-1:0] inst_mem_byte_enable,
  output rv32i_word       inst_mem_rdata,
  output logic            inst_mem_resp,

  input  rv32i_word       data_mem_address,
  input  logic            data_mem_read,
  input  logic            data_mem_write,
  input  logic [BE_W-1:0] data_mem_byte_enable,
  input  rv32i_word       data_mem_wdata,
  output rv32i_word       data_mem_rdata,
  output logic            data_mem_resp,

  output rv32i_word       pmem_address,
  output logic            pmem_read,
  output logic            pmem_write,
  output logic [BE_W-1:0] pmem_byte_enable,
  output rv32i_word       pmem_wdata,
  input  rv32i_word       pmem_rdata,
  input  logic            pmem_resp
);

  arb_state_t state_q, state_d;
  grant_t     last_grant_q, last_grant_d;
  logic       grant_vld_c;
  grant_t     grant_sel_c;
  logic       req_inst_c;
  logic       req_data_c;

  // The instruction port never writes; fold its write-side inputs away.
  logic unused_inst_wr;
  assign unused_inst_wr = ^{inst_mem_write, inst_mem_wdata, inst_mem_byte_enable};

  assign req_inst_c = inst_mem_read;
  assign req_data_c = data_mem_read | data_mem_write;

  // FSM state and grant history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_INST;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Grant decision and next state.
  always_comb begin
    state_d      = state_q;
    grant_vld_c  = 1'b0;
    grant_sel_c  = GRANT_INST;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        // Data wins when alone, under strict priority, or when inst had the last turn.
        if (req_data_c && (!req_inst_c || !FAIR || (last_grant_q == GRANT_INST))) begin
          grant_vld_c = 1'b1;
          grant_sel_c = GRANT_DATA;
          state_d     = DATA;
        end else if (req_inst_c) begin
          grant_vld_c = 1'b1;
          grant_sel_c = GRANT_INST;
          state_d     = INST;
        end
        if (grant_vld_c) begin
          last_grant_d = grant_sel_c;
        end
      end
      INST, DATA: begin
        if (pmem_resp) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Physical port request registers: loaded on grant, strobes cleared on completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pmem_address     <= '0;
      pmem_read        <= 1'b0;
      pmem_write       <= 1'b0;
      pmem_byte_enable <= '0;
      pmem_wdata       <= '0;
    end else if (grant_vld_c) begin
      if (grant_sel_c == GRANT_DATA) begin
        pmem_address     <= data_mem_address;
        // A simultaneous read+write is served as a write only.
        pmem_read        <= data_mem_read & ~data_mem_write;
        pmem_write       <= data_mem_write;
        pmem_byte_enable <= data_mem_byte_enable;
        pmem_wdata       <= data_mem_wdata;
      end else begin
        pmem_address     <= inst_mem_address;
        pmem_read        <= 1'b1;
        pmem_write       <= 1'b0;
        pmem_byte_enable <= BE_FULL;
        pmem_wdata       <= '0;
      end
    end else if ((state_q != IDLE) && pmem_resp) begin
      pmem_read  <= 1'b0;
      pmem_write <= 1'b0;
    end
  end

  // Read data passes straight through; only the resp pulse qualifies it.
  assign inst_mem_rdata = pmem_rdata;
  assign data_mem_rdata = pmem_rdata;
  assign inst_mem_resp  = (state_q == INST) & pmem_resp;
  assign data_mem_resp  = (state_q == DATA) & pmem_resp;

endmodule : mem_arbiter

// File: doc/mem_arbiter.md
# mem_arbiter

Responder-side counterpart of the CPU top's split memory interface: accepts the instruction-port and data-port requests and serves both from one shared physical memory port (`pmem_*`). It presents to the CPU the same read/write/resp handshake the CPU issues. It arbitrates contention, latches the granted request, and routes the one-cycle response pulse back to the correct requester. It sits between `cpu` and the cache/physical memory.

## Interface
- `FAIR`, default 1: 1 = alternate grants on contention; 0 = strict data-port priority.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-low.
- `inst_mem_address`  in  32  instruction fetch address.
- `inst_mem_read`  in  1  fetch request; held with address until `inst_mem_resp`.
- `inst_mem_write`, `inst_mem_wdata`, `inst_mem_byte_enable`  in  1/32/4  ignored.
- `inst_mem_rdata`  out  32  fetch data; valid only while `inst_mem_resp`=1.
- `inst_mem_resp`  out  1  one-cycle completion pulse.
- `data_mem_address`  in  32  load/store address.
- `data_mem_read`, `data_mem_write`  in  1  request strobes; held until `data_mem_resp`.
- `data_mem_byte_enable`  in  4  store byte lanes.
- `data_mem_wdata`  in  32  store data.
- `data_mem_rdata`  out  32  load data; valid only while `data_mem_resp`=1.
- `data_mem_resp`  out  1  one-cycle completion pulse; read and write both use it.
- `pmem_address`  out  32  latched address.
- `pmem_read`, `pmem_write`  out  1  registered strobes.
- `pmem_byte_enable`  out  4  latched lanes; 4'hF for fetches.
- `pmem_wdata`  out  32  latched store data.
- `pmem_rdata`  in  32  memory read data.
- `pmem_resp`  in  1  memory completion pulse.

## Operation
- States: IDLE, INST, DATA.
- In IDLE, the pending set is I = `inst_mem_read` and D = `data_mem_read | data_mem_write`.
  - D only: grant data.
  - I only: grant inst.
  - Both with FAIR=0: grant data.
  - Both with FAIR=1: grant the port opposite to `last_grant`. `last_grant` resets to inst, so data wins the first tie.
- On a grant, the arbiter registers the address, strobes, byte enable and wdata into the `pmem_*` output registers, updates `last_grant`, and moves to INST or DATA.
- If `data_mem_read` and `data_mem_write` are both high, the request is treated as a write and the read is dropped.
- In INST or DATA, the `pmem_*` outputs hold constant until `pmem_resp`.
- On `pmem_resp`:
  - The granted port's `*_resp` = 1 combinationally in the same cycle.
  - The granted port's `*_rdata` = `pmem_rdata`.
  - `pmem_read` and `pmem_write` clear on the next edge.
  - The state returns to IDLE.
- The non-granted port's resp stays 0 and its request stays pending. Requests are never dropped.
- `*_mem_rdata` may pass `pmem_rdata` through at all times. Only the resp qualifies it.
- A `pmem_resp` arriving in IDLE is ignored: no CPU resp and no state change.

## Timing
- Reset (async assert): state=IDLE, `last_grant`=inst. All outputs 0: `pmem_*` registers, both resp, both rdata (rdata may be passthrough, which is don't-care). Any in-flight pmem transaction is abandoned.
- Latency: request seen in IDLE at cycle t, `pmem_read`/`pmem_write` high at t+1. CPU resp appears in the same cycle as `pmem_resp`. Next IDLE evaluation happens at resp+1.
- There is exactly one dead cycle, the IDLE cycle, between back-to-back transactions. Throughput is at most one access per (pmem latency + 1) cycles.
- A requester holding its strobe high through its resp cycle is seen as a new request in the following IDLE cycle. This is legal and supports continuous fetch.
- `pmem_resp` in the same cycle as the state entry (t+1) completes the transaction. Minimum pmem latency is 1.

## Structure
- Add `arb_state_t` {IDLE, INST, DATA} and `grant_t` {GRANT_INST, GRANT_DATA} to a shared `mem_arbiter_types` package.
- Use `rv32i_word` from `rv32i_types`.
- Single module, no sub-modules. One FSM `always_ff`, one grant-decision `always_comb`, one output-register `always_ff`.

## Test plan
- Inst-only fetch at 0x60, pmem latency 3 → `pmem_read`=1 with `pmem_address`=0x60 and `pmem_byte_enable`=4'hF for 3 cycles; `inst_mem_resp` pulses once with rdata = `pmem_rdata`; `data_mem_resp` stays 0.
- Data store to 0x1004, be=4'b0011, wdata=0xDEADBEEF → `pmem_write`=1 with the latched values; `data_mem_resp` pulses; `pmem_read` stays 0.
- Both ports continuously requesting, FAIR=1 → grants go D, I, D, I; the port sequence is checked via resp pulses over 8 transactions. With FAIR=0 → all grants go to data while D is held.
- Data port asserts read and write together → only `pmem_write` is asserted.
- Stray `pmem_resp` in IDLE → no CPU resp and the state stays IDLE.
- Reset asserted mid-DATA with pmem latency 5 → all outputs 0 immediately, without waiting for a clock edge. After reset deassertion the held request is re-granted cleanly.
